// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory line port between the I-cache and the D-cache.
// D-cache has priority; a saturating starvation counter forces a waiting fetch through.
module pmem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
    logic                    pmem_read_q, pmem_read_d;
    logic                    pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0]   pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0]   pmem_wdata_q, pmem_wdata_d;
    logic                    d_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            starve_cnt_q   <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        d_req          = d_read | d_write;

        case (state_q)
            IDLE: begin
                // Fetch wins only when alone or when the D side has used up its run.
                if (i_read && (!d_req || starve_cnt_q >= LIMIT)) begin
                    state_d        = SERVE_I;
                    starve_cnt_d   = '0;
                    pmem_address_d = i_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                end else if (d_req) begin
                    state_d        = SERVE_D;
                    if (i_read && starve_cnt_q < LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                    pmem_address_d = d_address;
                    pmem_wdata_d   = d_wdata;
                    pmem_read_d    = d_read & ~d_write;
                    pmem_write_d   = d_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // Responses are qualified by rst_n so an abandoned transaction never completes.
    assign i_resp       = rst_n & (state_q == SERVE_I) & pmem_resp;
    assign d_resp       = rst_n & (state_q == SERVE_D) & pmem_resp;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level arbitration model.
module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
        tick(); tick();
        n_checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
        end
        n_checks++;
        if (pmem_address !== '0 || pmem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_regs: got addr %h wdata %h expected 0", pmem_address, pmem_wdata);
        end
        rst_n = 1'b1;
        tick();
        $display("reset: done");
    endtask

    task automatic test_i_read();
        logic [LW-1:0] a5 = {16{8'hA5}};
        i_read = 1; i_address = 16'h1230;
        tick();
        n_checks++;
        if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 16'h1230) begin
            n_fail++; $display("FAIL i_cmd: got r%b w%b a%h expected r1 w0 a1230", pmem_read, pmem_write, pmem_address);
        end
        pmem_rdata = a5; pmem_resp = 1; #1;
        n_checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== a5) begin
            n_fail++; $display("FAIL i_resp: got i%b d%b data %h expected i1 d0 data %h", i_resp, d_resp, i_rdata, a5);
        end
        tick();
        i_read = 0; pmem_resp = 0; #1;
        n_checks++;
        if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
            n_fail++; $display("FAIL i_done: got pmem_read %b i_resp %b expected 0 0", pmem_read, i_resp);
        end
        $display("i_read: addr 1230 served");
    endtask

    task automatic test_d_write();
        logic [LW-1:0] wd = {4{32'hDEAD_BEEF}};
        d_write = 1; d_address = 16'h4440; d_wdata = wd;
        tick();
        d_wdata = rand_line();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 16'h4440 || pmem_wdata !== wd || d_resp !== 1'b0) begin
                n_fail++; $display("FAIL d_write_hold[%0d]: got r%b w%b a%h resp%b expected r0 w1 a4440 resp0", c, pmem_read, pmem_write, pmem_address, d_resp);
            end
            tick();
        end
        pmem_resp = 1; #1;
        n_checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            n_fail++; $display("FAIL d_write_resp: got d%b i%b expected d1 i0", d_resp, i_resp);
        end
        tick();
        d_write = 0; pmem_resp = 0; #1;
        n_checks++;
        if (d_resp !== 1'b0 || pmem_write !== 1'b0 || pmem_wdata !== wd) begin
            n_fail++; $display("FAIL d_write_done: got resp %b write %b wdata %h expected 0 0 retained", d_resp, pmem_write, pmem_wdata);
        end
        $display("d_write: addr 4440 served after 5-cycle delay");
    endtask

    task automatic test_contention();
        i_read = 1; i_address = 16'h5550; d_read = 1; d_address = 16'h6660;
        tick();
        n_checks++;
        if (pmem_address !== 16'h6660 || pmem_read !== 1'b1) begin
            n_fail++; $display("FAIL contend_d_first: got a%h r%b expected a6660 r1", pmem_address, pmem_read);
        end
        pmem_resp = 1; #1;
        n_checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            n_fail++; $display("FAIL contend_d_resp: got d%b i%b expected d1 i0", d_resp, i_resp);
        end
        tick();
        d_read = 0; pmem_resp = 0; #1;
        n_checks++;
        if (pmem_read !== 1'b0) begin
            n_fail++; $display("FAIL contend_gap: got pmem_read %b expected 0", pmem_read);
        end
        tick();
        n_checks++;
        if (pmem_address !== 16'h5550 || pmem_read !== 1'b1) begin
            n_fail++; $display("FAIL contend_i_next: got a%h r%b expected a5550 r1", pmem_address, pmem_read);
        end
        pmem_resp = 1; #1;
        n_checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
            n_fail++; $display("FAIL contend_i_resp: got i%b d%b expected i1 d0", i_resp, d_resp);
        end
        tick();
        i_read = 0; pmem_resp = 0;
        $display("contention: D then I");
    endtask

    task automatic test_starvation();
        // Both sides keep requesting: expect SL D grants, one I grant, then D again.
        logic exp_i;
        i_read = 1; i_address = 16'h2000; d_read = 1;
        for (int k = 0; k <= SL + 1; k++) begin
            d_address = 16'h3000 + 16'(k * 16);
            exp_i = (k == SL);
            tick();
            n_checks++;
            if (pmem_address !== (exp_i ? 16'h2000 : d_address) || pmem_read !== 1'b1) begin
                n_fail++; $display("FAIL starve_grant[%0d]: got a%h expected a%h", k, pmem_address, exp_i ? 16'h2000 : d_address);
            end
            pmem_resp = 1; #1;
            n_checks++;
            if ({i_resp, d_resp} !== {exp_i, ~exp_i}) begin
                n_fail++; $display("FAIL starve_resp[%0d]: got i%b d%b expected i%b d%b", k, i_resp, d_resp, exp_i, ~exp_i);
            end
            tick();
            pmem_resp = 0;
            $display("starvation: grant %0d to %s", k, exp_i ? "I" : "D");
        end
        i_read = 0; d_read = 0;
        tick();
    endtask

    task automatic test_both_rw();
        d_read = 1; d_write = 1; d_address = 16'h7770; d_wdata = rand_line();
        tick();
        n_checks++;
        if ({pmem_read, pmem_write} !== 2'b01 || pmem_wdata !== d_wdata) begin
            n_fail++; $display("FAIL both_rw: got r%b w%b expected r0 w1", pmem_read, pmem_write);
        end
        pmem_resp = 1; tick();
        d_read = 0; d_write = 0; pmem_resp = 0;
        tick();
        $display("both_rw: write wins");
    endtask

    task automatic test_reset_mid();
        d_read = 1; d_address = 16'h8880;
        tick();
        n_checks++;
        if (pmem_read !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_start: got pmem_read %b expected 1", pmem_read);
        end
        rst_n = 0; pmem_resp = 1; #1;
        n_checks++;
        if (d_resp !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_resp_during: got d_resp %b expected 0", d_resp);
        end
        tick();
        n_checks++;
        if ({pmem_read, pmem_write, d_resp} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_after: got %b expected 000", {pmem_read, pmem_write, d_resp});
        end
        rst_n = 1; d_read = 0; #1;
        n_checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_late_resp: got i%b d%b expected i0 d0", i_resp, d_resp);
        end
        tick();
        n_checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            n_fail++; $display("FAIL idle_resp_ignored: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
        end
        pmem_resp = 0;
        tick();
        $display("reset_mid: transaction abandoned");
    endtask

    task automatic test_random(input int n);
        bit            i_pend = 0, d_pend = 0, exp_i, exp_rd, exp_wr, wd_known = 0, seen;
        int            cnt = 0, waited, delay;
        logic [AW-1:0] exp_a;
        logic [LW-1:0] exp_wd = '0, rd;
        for (int t = 0; t < n; t++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1; i_read = 1; i_address = AW'($urandom) & 16'hFFF0;
            end
            if (!d_pend && ($urandom_range(0, 1) == 1 || !i_pend)) begin
                int op = $urandom_range(0, 4);
                d_pend = 1; d_read = (op < 2 || op == 4); d_write = (op >= 2);
                d_address = AW'($urandom) & 16'hFFF0; d_wdata = rand_line();
            end
            // Reference arbitration from the rules: D first unless I has waited SL D grants.
            exp_i = i_pend && (!d_pend || cnt >= SL);
            if (exp_i) cnt = 0;
            else if (i_pend) cnt = (cnt < SL) ? cnt + 1 : SL;
            exp_a  = exp_i ? i_address : d_address;
            exp_rd = exp_i ? 1'b1 : (d_read & ~d_write);
            exp_wr = exp_i ? 1'b0 : d_write;
            if (!exp_i) begin exp_wd = d_wdata; wd_known = 1; end
            waited = 0; seen = 0;
            while (!seen && waited < 8) begin
                tick(); waited++;
                seen = pmem_read | pmem_write;
            end
            n_checks++;
            if (waited != 1 || !seen) begin
                n_fail++; $display("FAIL rnd_latency[%0d]: got %0d cycles expected 1", t, waited);
                rst_n = 0; tick(); rst_n = 1;
                i_read = 0; d_read = 0; d_write = 0; i_pend = 0; d_pend = 0; cnt = 0;
                continue;
            end
            delay = $urandom_range(0, 3);
            for (int c = 0; c <= delay; c++) begin
                n_checks++;
                if (pmem_address !== exp_a || {pmem_read, pmem_write} !== {exp_rd, exp_wr}
                    || (wd_known && pmem_wdata !== exp_wd) || i_resp !== 1'b0 || d_resp !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_cmd[%0d]: got a%h r%b w%b expected a%h r%b w%b owner %s", t, pmem_address, pmem_read, pmem_write, exp_a, exp_rd, exp_wr, exp_i ? "I" : "D");
                end
                if (c < delay) tick();
            end
            rd = rand_line(); pmem_rdata = rd; pmem_resp = 1; #1;
            n_checks++;
            if ({i_resp, d_resp} !== {exp_i, ~exp_i} || (exp_i ? i_rdata : d_rdata) !== rd) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: got i%b d%b expected i%b d%b", t, i_resp, d_resp, exp_i, ~exp_i);
            end
            tick();
            pmem_resp = 0;
            if (exp_i) begin i_read = 0; i_pend = 0; end
            else begin d_read = 0; d_write = 0; d_pend = 0; end
            #1;
            n_checks++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
                n_fail++; $display("FAIL rnd_idle[%0d]: got %b expected 0000", t, {pmem_read, pmem_write, i_resp, d_resp});
            end
            $display("random[%0d]: %s addr %h delay %0d", t, exp_i ? "I" : "D", exp_a, delay);
        end
        i_read = 0; d_read = 0; d_write = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_contention();
        test_starvation();
        test_both_rw();
        test_reset_mid();
        test_random(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
